// File: rtl/pulse_stretcher_queue.sv
// Stretches single-cycle event pulses into timed output levels with a guaranteed low gap.
// Events arriving while a pulse is active are counted and replayed one by one.
module pulse_stretcher_queue #(
   parameter int CLK_PER_US = 36,
   parameter int HIGH_US    = 1000,
   parameter int LOW_US     = 500,
   parameter int QUEUE_BITS = 4
) (
   input  logic                  clk_36MHz,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  trigger,
   output logic                  out,
   output logic                  busy,
   output logic [QUEUE_BITS-1:0] pending,
   output logic                  overflow
);

   localparam int US_MAX = (HIGH_US > LOW_US) ? HIGH_US : LOW_US;
   localparam int US_W   = $clog2(US_MAX + 1);
   localparam int PS_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   localparam logic [PS_W-1:0]       PS_LAST   = PS_W'(CLK_PER_US - 1);
   localparam logic [US_W-1:0]       HIGH_LAST = US_W'(HIGH_US - 1);
   localparam logic [US_W-1:0]       LOW_LAST  = US_W'(LOW_US - 1);
   localparam logic [QUEUE_BITS-1:0] PEND_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [PS_W-1:0]         presc_q, presc_d;
   logic [US_W-1:0]         us_q, us_d;
   logic [QUEUE_BITS-1:0]   pend_q, pend_d;
   logic                    ovf_q, ovf_d;
   logic                    out_q, out_d;
   logic                    busy_q, busy_d;

   logic                    us_tick;
   logic                    enq;
   logic                    deq;
   logic                    enter;

   assign us_tick = (presc_q == PS_LAST);

   always_ff @(posedge clk_36MHz) begin
      if (reset) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         us_q    <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         us_q    <= us_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      us_d    = us_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      out_d   = out_q;
      busy_d  = busy_q;
      enq     = 1'b0;
      deq     = 1'b0;
      enter   = 1'b0;

      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (trigger) begin
                  state_d = S_HIGH;
                  enter   = 1'b1;
               end
            end
            S_HIGH: begin
               enq = trigger;
               if (us_tick && (us_q == HIGH_LAST)) begin
                  state_d = S_GAP;
                  enter   = 1'b1;
               end
            end
            S_GAP: begin
               if (us_tick && (us_q == LOW_LAST)) begin
                  enter = 1'b1;
                  // A queued event takes precedence; a same-cycle trigger then refills its slot.
                  if (pend_q != '0) begin
                     state_d = S_HIGH;
                     deq     = 1'b1;
                     enq     = trigger;
                  end else begin
                     state_d = trigger ? S_HIGH : S_IDLE;
                  end
               end else begin
                  enq = trigger;
               end
            end
            default: begin
               state_d = S_IDLE;
               enter   = 1'b1;
            end
         endcase

         if (enq && !deq) begin
            if (pend_q == PEND_MAX) begin
               ovf_d = 1'b1;
            end else begin
               pend_d = pend_q + QUEUE_BITS'(1);
            end
         end else if (deq && !enq) begin
            pend_d = pend_q - QUEUE_BITS'(1);
         end

         // Timers restart on every state entry so each phase has an exact length.
         if (enter) begin
            presc_d = '0;
            us_d    = '0;
         end else if ((state_q == S_HIGH) || (state_q == S_GAP)) begin
            presc_d = us_tick ? '0 : presc_q + PS_W'(1);
            us_d    = us_tick ? us_q + US_W'(1) : us_q;
         end

         out_d  = (state_d == S_HIGH);
         busy_d = (state_d == S_HIGH) || (state_d == S_GAP);
      end
   end

   assign out      = out_q;
   assign busy     = busy_q;
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher_queue.sv
// Bench for pulse_stretcher_queue: a monitor measures every out pulse against widths
// queued by the scenario tasks, which also check timing points and status inline.
module tb_pulse_stretcher_queue;

   localparam int CPU = 36;
   localparam int HUS = 3;
   localparam int LUS = 2;
   localparam int QB  = 2;
   localparam int HIGH_CYC = CPU * HUS;
   localparam int LOW_CYC  = CPU * LUS;
   localparam int PERIOD   = HIGH_CYC + LOW_CYC;

   logic          clk_36MHz = 1'b0;
   logic          reset;
   logic          enable;
   logic          trigger;
   logic          out;
   logic          busy;
   logic [QB-1:0] pending;
   logic          overflow;

   int total = 0;
   int bad   = 0;
   int exp_w[$];

   pulse_stretcher_queue #(
      .CLK_PER_US(CPU),
      .HIGH_US   (HUS),
      .LOW_US    (LUS),
      .QUEUE_BITS(QB)
   ) dut (
      .clk_36MHz(clk_36MHz),
      .reset    (reset),
      .enable   (enable),
      .trigger  (trigger),
      .out      (out),
      .busy     (busy),
      .pending  (pending),
      .overflow (overflow)
   );

   always #14 clk_36MHz = ~clk_36MHz;

   // Pulse-width monitor: pops the expected width for every completed out pulse.
   int   mon_cyc = 0;
   int   start_cyc = 0;
   int   width;
   int   ew;
   logic prev_out = 1'b0;

   always @(posedge clk_36MHz) begin
      #1;
      mon_cyc++;
      if (out === 1'b1 && prev_out === 1'b0) start_cyc = mon_cyc;
      if (out === 1'b0 && prev_out === 1'b1) begin
         width = mon_cyc - start_cyc;
         total++;
         if (exp_w.size() == 0) begin
            bad++;
            $display("FAIL pulse_width: got unexpected pulse of %0d cycles, none expected", width);
         end else begin
            ew = exp_w.pop_front();
            if (width != ew) begin
               bad++;
               $display("FAIL pulse_width: got %0d cycles, expected %0d", width, ew);
            end
         end
      end
      prev_out = out;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_36MHz);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; trigger = 1'b0;
      tick(3);
      total++; if (out !== 1'b0) begin bad++; $display("FAIL reset_out: got %b expected 0", out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      total++; if (pending !== 2'd0) begin bad++; $display("FAIL reset_pending: got %0d expected 0", pending); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      reset = 1'b0;
      tick(5);
   endtask

   task automatic test_single;
      exp_w.push_back(HIGH_CYC);
      trigger = 1'b1; tick(1); trigger = 1'b0;
      total++; if (out !== 1'b1) begin bad++; $display("FAIL single_latency: out got %b expected 1", out); end
      tick(HIGH_CYC - 1);
      total++; if (out !== 1'b1) begin bad++; $display("FAIL single_last_high: out got %b expected 1", out); end
      tick(1);
      total++; if (out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_gap_start: out/busy got %b%b expected 01", out, busy); end
      tick(LOW_CYC - 1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_last_gap: busy got %b expected 1", busy); end
      tick(1);
      total++; if (busy !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL single_idle: busy=%b pending=%0d expected 0/0", busy, pending); end
      tick(10);
   endtask

   task automatic test_queue;
      int k;
      repeat (3) exp_w.push_back(HIGH_CYC);
      trigger = 1'b1; tick(1); trigger = 1'b0; k = 1;
      tick(10 - k); k = 10;
      trigger = 1'b1; tick(1); trigger = 1'b0; k = 11;
      total++; if (pending !== 2'd1) begin bad++; $display("FAIL queue_pend1: got %0d expected 1", pending); end
      tick(20 - k); k = 20;
      trigger = 1'b1; tick(1); trigger = 1'b0; k = 21;
      total++; if (pending !== 2'd2) begin bad++; $display("FAIL queue_pend2: got %0d expected 2", pending); end
      tick(PERIOD - k); k = PERIOD;
      total++; if (out !== 1'b0 || pending !== 2'd2) begin bad++; $display("FAIL queue_gap_end: out=%b pending=%0d expected 0/2", out, pending); end
      tick(1); k++;
      total++; if (out !== 1'b1 || pending !== 2'd1) begin bad++; $display("FAIL queue_second: out=%b pending=%0d expected 1/1", out, pending); end
      tick(2 * PERIOD + 1 - k); k = 2 * PERIOD + 1;
      total++; if (out !== 1'b1 || pending !== 2'd0) begin bad++; $display("FAIL queue_third: out=%b pending=%0d expected 1/0", out, pending); end
      tick(3 * PERIOD + 1 - k); k = 3 * PERIOD + 1;
      total++; if (busy !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL queue_idle: busy=%b overflow=%b expected 0/0", busy, overflow); end
      tick(10);
   endtask

   task automatic test_overflow;
      repeat (4) exp_w.push_back(HIGH_CYC);
      trigger = 1'b1; tick(6); trigger = 1'b0;
      total++; if (pending !== 2'd3) begin bad++; $display("FAIL ovf_pending: got %0d expected 3", pending); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      tick(4 * PERIOD - 6);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_last_gap: busy got %b expected 1", busy); end
      tick(1);
      total++; if (busy !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL ovf_idle: busy=%b pending=%0d expected 0/0", busy, pending); end
      tick(20);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      reset = 1'b1; tick(1); reset = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_reset_clear: got %b expected 0", overflow); end
      tick(5);
   endtask

   task automatic test_back_to_back;
      repeat (2) exp_w.push_back(HIGH_CYC);
      trigger = 1'b1; tick(1); trigger = 1'b0;
      tick(PERIOD - 1);
      total++; if (out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_last_gap: out/busy got %b%b expected 01", out, busy); end
      trigger = 1'b1; tick(1); trigger = 1'b0;
      total++; if (out !== 1'b1 || pending !== 2'd0) begin bad++; $display("FAIL b2b_rehigh: out=%b pending=%0d expected 1/0", out, pending); end
      tick(PERIOD);
      total++; if (busy !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL b2b_idle: busy=%b pending=%0d expected 0/0", busy, pending); end
      tick(10);
   endtask

   task automatic test_enable;
      exp_w.push_back(HIGH_CYC + 50);
      trigger = 1'b1; tick(1); trigger = 1'b0;
      tick(29);
      enable = 1'b0;
      tick(10);
      trigger = 1'b1; tick(5); trigger = 1'b0;
      tick(20);
      total++; if (out !== 1'b1 || pending !== 2'd0) begin bad++; $display("FAIL en_frozen: out=%b pending=%0d expected 1/0", out, pending); end
      tick(15);
      enable = 1'b1;
      tick(HIGH_CYC + 50 - 80);
      total++; if (out !== 1'b1) begin bad++; $display("FAIL en_stretched_end: out got %b expected 1", out); end
      tick(1);
      total++; if (out !== 1'b0 || pending !== 2'd0) begin bad++; $display("FAIL en_fall: out=%b pending=%0d expected 0/0", out, pending); end
      tick(LOW_CYC);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_idle: busy got %b expected 0", busy); end
      tick(10);
   endtask

   task automatic test_reset_mid;
      exp_w.push_back(60);
      trigger = 1'b1; tick(1); trigger = 1'b0;
      tick(9);
      trigger = 1'b1; tick(1); trigger = 1'b0;
      tick(9);
      trigger = 1'b1; tick(1); trigger = 1'b0;
      tick(39);
      total++; if (pending !== 2'd2 || out !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: pending=%0d out=%b expected 2/1", pending, out); end
      reset = 1'b1; tick(1); reset = 1'b0;
      total++; if (out !== 1'b0 || busy !== 1'b0 || pending !== 2'd0 || overflow !== 1'b0)
         begin bad++; $display("FAIL rst_mid_clear: out=%b busy=%b pending=%0d overflow=%b expected all 0", out, busy, pending, overflow); end
      tick(2 * PERIOD);
      total++; if (busy !== 1'b0 || out !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet: busy=%b out=%b expected 0/0", busy, out); end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; trigger = 1'b0;
      test_reset;
      test_single;
      test_queue;
      test_overflow;
      test_back_to_back;
      test_enable;
      test_reset_mid;
      tick(2);
      total++;
      if (exp_w.size() != 0) begin
         bad++;
         $display("FAIL pulses_missing: %0d expected pulses never seen, expected 0", exp_w.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_stretcher_queue.md
Name: pulse_stretcher_queue

Overview:
Output-side counterpart to the input debouncers. It takes clean single-cycle event pulses from game logic (shot fired, invader hit) and turns each one into a timed level on an LED or buzzer pin. The output stays high for a fixed number of microseconds, then a guaranteed low gap follows. Triggers that arrive while a pulse is in progress are counted and replayed, so each event gives a separate, visible output pulse.

Parameters:
CLK_PER_US, 36, clk_36MHz cycles per microsecond tick.
HIGH_US, 1000, output high time in µs (≥1).
LOW_US, 500, minimum low gap after each pulse in µs (≥1).
QUEUE_BITS, 4, width of the pending-trigger counter; max pending = 2^QUEUE_BITS−1.

Ports:
clk_36MHz  input  1  system clock, 36 MHz.
reset  input  1  synchronous, active-high.
enable  input  1  when 0, freezes state, prescaler, µs counter and pending; trigger is ignored.
trigger  input  1  event pulse; each cycle sampled high while enable=1 is one event.
out  output  1  stretched level, registered.
busy  output  1  high in HIGH or GAP state, registered.
pending  output  QUEUE_BITS  count of queued events not yet issued.
overflow  output  1  sticky; set when an event is lost because the queue is full.

Behaviour:
- Reset (synchronous, takes priority over everything): state=IDLE; out=0, busy=0, pending=0, overflow=0; prescaler=0, µs counter=0.
- Prescaler counts 0..CLK_PER_US−1 and wraps. us_tick is asserted on the wrap cycle. Prescaler and µs counter both clear on every state entry, so durations are exact.
- States:
  - IDLE: out=0, busy=0. On trigger, go to HIGH next cycle. out=1 in the cycle after the trigger is sampled (latency 1).
  - HIGH: out=1, busy=1. Lasts exactly HIGH_US*CLK_PER_US cycles, then goes to GAP.
  - GAP: out=0, busy=1. Lasts exactly LOW_US*CLK_PER_US cycles.
    - At the end of GAP with pending>0: pending decrements, go to HIGH. out rises in the cycle right after the last GAP cycle.
    - At the end of GAP with pending=0: go to IDLE.
  - Any unreachable state encoding returns to IDLE with out=0.
- Trigger during HIGH or GAP: pending += 1.
- Trigger with pending at max: pending holds at max and overflow is set to 1. overflow clears only on reset.
- Trigger on the same cycle GAP ends with pending>0: dequeue and enqueue cancel, so pending is unchanged and HIGH is entered.
- Trigger on the same cycle GAP ends with pending=0: counts as an IDLE trigger; go straight to HIGH, pending stays 0.
- A trigger held high for N consecutive enabled cycles counts as N events.
- enable=0: all registers hold, and out/busy hold their values. A pulse in progress is stretched by the number of disabled cycles. When enable returns to 1, timing resumes where it stopped.
- Reset mid-pulse: out drops to 0 in the cycle after reset is sampled, and all queued events are discarded.
- Width rules:
  - µs counter width is clog2(max(HIGH_US, LOW_US)+1).
  - Prescaler width is clog2(CLK_PER_US).
  - pending never wraps.

Test Plan:
(Parameters for all tests: CLK_PER_US=36, HIGH_US=3, LOW_US=2, QUEUE_BITS=2.)
1. Single trigger at cycle 10 from IDLE → out=1 for cycles 11–118 (108 cycles), busy=1 for cycles 11–190, IDLE at cycle 191; pending stays 0.
2. Triggers at cycles 10, 20, 30 → three out pulses of 108 cycles each, separated by 72-cycle gaps. pending reads 2 after cycle 30 and steps 2→1→0 at each re-entry to HIGH; overflow=0.
3. Five triggers during the first HIGH → pending saturates at 3 and overflow=1. Exactly 4 pulses total, then IDLE; overflow stays 1 until reset.
4. Trigger coincident with the last GAP cycle, pending=0 → HIGH entered on the next cycle with no extra idle cycle; pending=0 throughout.
5. enable=0 for 50 cycles mid-HIGH → out high for 158 cycles total; trigger pulses during the disabled window are not counted.
6. reset asserted at cycle 60 of HIGH with pending=2 → next cycle out=0, busy=0, pending=0, overflow=0; no further pulses.
